// File: rtl/lsu_done_merge_if.sv
// ----------------------------------------------------------------------------
// lsu_done_merge_if
// Bundle of the signals between the SGPR/VGPR write-back completion sources,
// the completion merge stage and the memory-wait tracker.
//   f_sgpr_lsu_instr_done / _wfid : SGPR-side completion event and its wavefront
//   f_vgpr_lsu_wr_done / _wfid    : VGPR-side completion event and its wavefront
//   lsu_done / lsu_done_wfid      : merged single-cycle completion pulse + wfid
//   idle                          : nothing buffered and no pulse in flight
//   merge_overflow                : sticky drop indicator (optional feature)
// Modports: slave = the merge stage, master = its environment.
// ----------------------------------------------------------------------------
interface lsu_done_merge_if #(
  parameter int WFID_W = 6
);
  logic              f_sgpr_lsu_instr_done;
  logic [WFID_W-1:0] f_sgpr_lsu_instr_done_wfid;
  logic              f_vgpr_lsu_wr_done;
  logic [WFID_W-1:0] f_vgpr_lsu_wr_done_wfid;
  logic              lsu_done;
  logic [WFID_W-1:0] lsu_done_wfid;
  logic              idle;
  logic              merge_overflow;

  modport slave (
    input  f_sgpr_lsu_instr_done, f_sgpr_lsu_instr_done_wfid,
    input  f_vgpr_lsu_wr_done, f_vgpr_lsu_wr_done_wfid,
    output lsu_done, lsu_done_wfid, idle, merge_overflow
  );

  modport master (
    output f_sgpr_lsu_instr_done, f_sgpr_lsu_instr_done_wfid,
    output f_vgpr_lsu_wr_done, f_vgpr_lsu_wr_done_wfid,
    input  lsu_done, lsu_done_wfid, idle, merge_overflow
  );
endinterface

// File: rtl/lsu_done_merge.sv
// ----------------------------------------------------------------------------
// lsu_done_merge
// Merges LSU completion events from the SGPR and VGPR write-back ports into a
// single one-event-per-cycle lsu_done/lsu_done_wfid stream. Each source has its
// own circular FIFO; under contention the two FIFOs are popped in strict
// alternation. No backpressure: a push into a full FIFO that is not popped in
// the same cycle is dropped.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-low reset
//   bus  : lsu_done_merge_if.slave (source events in, merged stream/status out)
// Parameters: DEPTH (entries per FIFO, power of two >= 2), WFID_W.
// Optional feature macro: LSU_DONE_MERGE_OVF_CHK_EN
//   defined   -> merge_overflow is a sticky drop flag, simulation reports drops
//   undefined -> merge_overflow tied to 0
// ----------------------------------------------------------------------------
module lsu_done_merge #(
  parameter int DEPTH  = 8,
  parameter int WFID_W = 6
) (
  input logic            clk,
  input logic            rst,
  lsu_done_merge_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  // Index 0 = S (SGPR) FIFO, index 1 = V (VGPR) FIFO.
  logic [1:0]             in_valid;
  logic [1:0][WFID_W-1:0] in_wfid;
  logic [1:0]             empty;
  logic [1:0]             full;
  logic [1:0]             push;
  logic [1:0]             pop;
  logic [1:0][WFID_W-1:0] head;

  logic                   prio_reg;   // 0 = S next under contention, 1 = V
  logic                   done_reg;
  logic [WFID_W-1:0]      wfid_reg;

  assign in_valid = {bus.f_vgpr_lsu_wr_done, bus.f_sgpr_lsu_instr_done};
  assign in_wfid  = {bus.f_vgpr_lsu_wr_done_wfid, bus.f_sgpr_lsu_instr_done_wfid};

  // A lone non-empty FIFO always wins; prio only decides under contention.
  assign pop[0] = !empty[0] && (empty[1] || !prio_reg);
  assign pop[1] = !empty[1] && (empty[0] ||  prio_reg);

  // A full FIFO still accepts a push when it is popped in the same cycle.
  assign push = in_valid & (~full | pop);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [WFID_W-1:0] mem [DEPTH];
      logic [PTR_W-1:0]  rd_ptr_reg;
      logic [PTR_W-1:0]  wr_ptr_reg;

      assign empty[gi] = (rd_ptr_reg == wr_ptr_reg);
      assign full[gi]  = (rd_ptr_reg[AW] != wr_ptr_reg[AW]) &&
                         (rd_ptr_reg[AW-1:0] == wr_ptr_reg[AW-1:0]);
      assign head[gi]  = mem[rd_ptr_reg[AW-1:0]];

      // Storage carries no reset; validity is defined by the pointers.
      always_ff @(posedge clk) begin
        if (push[gi]) begin
          mem[wr_ptr_reg[AW-1:0]] <= in_wfid[gi];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_reg <= 1'b0;
      done_reg <= 1'b0;
      wfid_reg <= '0;
    end else begin
      done_reg <= |pop;
      if (pop[0]) begin
        wfid_reg <= head[0];
      end else if (pop[1]) begin
        wfid_reg <= head[1];
      end
      if (!empty[0] && !empty[1]) begin
        prio_reg <= !prio_reg;
      end
    end
  end

  assign bus.lsu_done      = done_reg;
  assign bus.lsu_done_wfid = wfid_reg;
  assign bus.idle          = empty[0] && empty[1] && !done_reg;

`ifdef LSU_DONE_MERGE_OVF_CHK_EN
  logic [1:0] drop;
  logic       ovf_reg;

  assign drop = in_valid & full & ~pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_reg <= 1'b0;
    end else if (|drop) begin
      ovf_reg <= 1'b1;
    end
  end

  assign bus.merge_overflow = ovf_reg;

`ifndef SYNTHESIS
  logic [31:0] cyc_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_reg <= '0;
    end else begin
      cyc_reg <= cyc_reg + 32'd1;
      if (drop[0]) $info("lsu_done_merge: cycle %0d: SGPR completion dropped (FIFO full)", cyc_reg);
      if (drop[1]) $info("lsu_done_merge: cycle %0d: VGPR completion dropped (FIFO full)", cyc_reg);
    end
  end
`endif
`else
  assign bus.merge_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_done_merge.sv
// ----------------------------------------------------------------------------
// tb_lsu_done_merge
// Self-checking bench for lsu_done_merge. A queue-based reference model (one
// queue per source, a priority bit, drop on a full queue with no pop) predicts
// the merged stream; each test task compares the DUT against it and against
// literal expected sequences for the directed scenarios.
// ----------------------------------------------------------------------------
module tb_lsu_done_merge;
  localparam int DEPTH  = 8;
  localparam int WFID_W = 6;
`ifdef LSU_DONE_MERGE_OVF_CHK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  lsu_done_merge_if #(.WFID_W(WFID_W)) bus ();

  lsu_done_merge #(.DEPTH(DEPTH), .WFID_W(WFID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int               sq[$];
  int               vq[$];
  bit               mprio;
  bit               exp_done;
  logic [WFID_W-1:0] exp_wfid;
  bit               exp_idle;
  bit               dropped;
  bit               exp_ovf;

  int n_pass;
  int n_total;

  // One clock: drive inputs, take the edge, advance the model, sample #1 later.
  task automatic step(input bit r, input bit sv, input int sw, input bit vv, input int vw);
    bit ps, pv;
    rst = r;
    bus.f_sgpr_lsu_instr_done      = sv;
    bus.f_sgpr_lsu_instr_done_wfid = WFID_W'(sw);
    bus.f_vgpr_lsu_wr_done         = vv;
    bus.f_vgpr_lsu_wr_done_wfid    = WFID_W'(vw);
    @(posedge clk);
    if (!r) begin
      sq.delete();
      vq.delete();
      mprio    = 1'b0;
      exp_done = 1'b0;
      exp_wfid = '0;
      dropped  = 1'b0;
    end else begin
      ps = 1'b0;
      pv = 1'b0;
      if (sq.size() > 0 && vq.size() > 0) begin
        if (!mprio) ps = 1'b1; else pv = 1'b1;
        mprio = !mprio;
      end else if (sq.size() > 0) begin
        ps = 1'b1;
      end else if (vq.size() > 0) begin
        pv = 1'b1;
      end
      exp_done = ps | pv;
      if (ps) exp_wfid = WFID_W'(sq.pop_front());
      else if (pv) exp_wfid = WFID_W'(vq.pop_front());
      if (sv) begin
        if (sq.size() < DEPTH) sq.push_back(sw); else dropped = 1'b1;
      end
      if (vv) begin
        if (vq.size() < DEPTH) vq.push_back(vw); else dropped = 1'b1;
      end
    end
    exp_idle = (sq.size() == 0) && (vq.size() == 0) && !exp_done;
    exp_ovf  = OVF_EN && dropped;
    #1;
    rst = 1'b1;
    bus.f_sgpr_lsu_instr_done = 1'b0;
    bus.f_vgpr_lsu_wr_done    = 1'b0;
  endtask

  task automatic test_reset();
    step(0, 1, 9, 1, 9);
    step(0, 0, 0, 0, 0);
    n_total++;
    if ({bus.lsu_done, bus.lsu_done_wfid, bus.idle, bus.merge_overflow} !== {1'b0, 6'd0, 1'b1, 1'b0})
      $display("FAIL reset: got done=%0b wfid=%0d idle=%0b ovf=%0b, want 0/0/1/0",
               bus.lsu_done, bus.lsu_done_wfid, bus.idle, bus.merge_overflow);
    else n_pass++;
  endtask

  task automatic test_single();
    step(1, 1, 5, 0, 0);
    n_total++;
    if (bus.lsu_done !== 1'b0 || bus.idle !== 1'b0)
      $display("FAIL single_edge1: got done=%0b idle=%0b, want done=0 idle=0", bus.lsu_done, bus.idle);
    else n_pass++;
    step(1, 0, 0, 0, 0);
    n_total++;
    if (bus.lsu_done !== 1'b1 || bus.lsu_done_wfid !== 6'd5)
      $display("FAIL single_edge2: got done=%0b wfid=%0d, want done=1 wfid=5", bus.lsu_done, bus.lsu_done_wfid);
    else n_pass++;
    step(1, 0, 0, 0, 0);
    n_total++;
    if (bus.idle !== 1'b1 || bus.lsu_done !== 1'b0 || bus.lsu_done_wfid !== 6'd5)
      $display("FAIL single_idle: got idle=%0b done=%0b wfid=%0d, want idle=1 done=0 wfid=5",
               bus.idle, bus.lsu_done, bus.lsu_done_wfid);
    else n_pass++;
  endtask

  task automatic test_pairs();
    int order[8] = '{1, 11, 2, 12, 3, 13, 4, 14};
    for (int i = 0; i < 10; i++) begin
      if (i < 4) step(1, 1, 1 + i, 1, 11 + i);
      else       step(1, 0, 0, 0, 0);
      if (i >= 1 && i <= 8) begin
        n_total++;
        if (bus.lsu_done !== 1'b1 || bus.lsu_done_wfid !== 6'(order[i-1]) || bus.merge_overflow !== 1'b0)
          $display("FAIL pairs_pulse%0d: got done=%0b wfid=%0d ovf=%0b, want done=1 wfid=%0d ovf=0",
                   i - 1, bus.lsu_done, bus.lsu_done_wfid, bus.merge_overflow, order[i-1]);
        else n_pass++;
      end
    end
    n_total++;
    if (bus.lsu_done !== 1'b0 || bus.idle !== 1'b1)
      $display("FAIL pairs_end: got done=%0b idle=%0b, want done=0 idle=1", bus.lsu_done, bus.idle);
    else n_pass++;
  endtask

  task automatic test_same_wfid();
    step(1, 1, 7, 1, 7);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0, 0);
      n_total++;
      if (bus.lsu_done !== 1'b1 || bus.lsu_done_wfid !== 6'd7)
        $display("FAIL same_wfid_pulse%0d: got done=%0b wfid=%0d, want done=1 wfid=7",
                 i, bus.lsu_done, bus.lsu_done_wfid);
      else n_pass++;
    end
    step(1, 0, 0, 0, 0);
    n_total++;
    if (bus.lsu_done !== 1'b0)
      $display("FAIL same_wfid_end: got done=%0b, want 0", bus.lsu_done);
    else n_pass++;
  endtask

  // Both sources every cycle until both FIFOs are full: the popped FIFO accepts
  // its push while the other drops, then a long drain checks order.
  task automatic test_overflow();
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      if (i < 24) step(1, 1, i, 1, 32 + i);
      else        step(1, 0, 0, 0, 0);
      n_total++;
      if ({bus.lsu_done, bus.lsu_done_wfid, bus.idle, bus.merge_overflow} !==
          {exp_done, exp_wfid, exp_idle, exp_ovf})
        $display("FAIL overflow_cyc%0d: got done=%0b wfid=%0d idle=%0b ovf=%0b, want %0b/%0d/%0b/%0b",
                 i, bus.lsu_done, bus.lsu_done_wfid, bus.idle, bus.merge_overflow,
                 exp_done, exp_wfid, exp_idle, exp_ovf);
      else n_pass++;
    end
    n_total++;
    if (bus.merge_overflow !== OVF_EN)
      $display("FAIL overflow_sticky: got ovf=%0b, want %0b", bus.merge_overflow, OVF_EN);
    else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 40 + i, 1, 50 + i);
    step(0, 0, 0, 0, 0);
    n_total++;
    if (bus.lsu_done !== 1'b0 || bus.idle !== 1'b1 || bus.merge_overflow !== 1'b0)
      $display("FAIL middrain_reset: got done=%0b idle=%0b ovf=%0b, want 0/1/0",
               bus.lsu_done, bus.idle, bus.merge_overflow);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0);
      n_total++;
      if (bus.lsu_done !== 1'b0 || bus.idle !== 1'b1)
        $display("FAIL middrain_quiet%0d: got done=%0b idle=%0b, want 0/1", i, bus.lsu_done, bus.idle);
      else n_pass++;
    end
    step(1, 1, 21, 1, 31);
    step(1, 0, 0, 0, 0);
    n_total++;
    if (bus.lsu_done !== 1'b1 || bus.lsu_done_wfid !== 6'd21)
      $display("FAIL middrain_prio_s: got done=%0b wfid=%0d, want done=1 wfid=21", bus.lsu_done, bus.lsu_done_wfid);
    else n_pass++;
    step(1, 0, 0, 0, 0);
    n_total++;
    if (bus.lsu_done !== 1'b1 || bus.lsu_done_wfid !== 6'd31)
      $display("FAIL middrain_then_v: got done=%0b wfid=%0d, want done=1 wfid=31", bus.lsu_done, bus.lsu_done_wfid);
    else n_pass++;
    step(1, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    bit sv, vv;
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      sv = (i < 380) && ($urandom_range(0, 3) != 0);
      vv = (i < 380) && ($urandom_range(0, 3) != 0);
      step(1, sv, int'($urandom_range(0, 63)), vv, int'($urandom_range(0, 63)));
      n_total++;
      if ({bus.lsu_done, bus.lsu_done_wfid, bus.idle, bus.merge_overflow} !==
          {exp_done, exp_wfid, exp_idle, exp_ovf})
        $display("FAIL random_cyc%0d: got done=%0b wfid=%0d idle=%0b ovf=%0b, want %0b/%0d/%0b/%0b",
                 i, bus.lsu_done, bus.lsu_done_wfid, bus.idle, bus.merge_overflow,
                 exp_done, exp_wfid, exp_idle, exp_ovf);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b0;
    bus.f_sgpr_lsu_instr_done      = 1'b0;
    bus.f_sgpr_lsu_instr_done_wfid = '0;
    bus.f_vgpr_lsu_wr_done         = 1'b0;
    bus.f_vgpr_lsu_wr_done_wfid    = '0;
    test_reset();
    test_single();
    test_pairs();
    test_same_wfid();
    test_overflow();
    test_reset_mid_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
